// File: rtl/add_reservation_station.sv
// Reservation station for the ADD/SUB unit: holds renamed ADD-class instructions,
// snoops both CDBs for pending operands and dispatches the oldest ready entry.
module add_reservation_station #(
  parameter int         ENTRIES  = 3,
  parameter logic [2:0] TAG_BASE = 3'd1,
  parameter int         DW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [7:0]    issue_op,
  input  logic [DW-1:0] issue_op1,
  input  logic [2:0]    issue_op1_tag,
  input  logic          issue_op1_vbit,
  input  logic [DW-1:0] issue_op2,
  input  logic [2:0]    issue_op2_tag,
  input  logic          issue_op2_vbit,
  output logic [2:0]    alloc_tag,
  output logic          rs_full,
  input  logic [2:0]    cdb_add_tag,
  input  logic [DW-1:0] cdb_add_data,
  input  logic [2:0]    cdb_mul_tag,
  input  logic [DW-1:0] cdb_mul_data,
  input  logic          exu_ready,
  output logic          disp_valid,
  output logic [7:0]    disp_op,
  output logic [DW-1:0] disp_a,
  output logic [DW-1:0] disp_b,
  output logic [2:0]    disp_tag
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] vb1;
  logic [ENTRIES-1:0] vb2;
  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] vb1_n;
  logic [ENTRIES-1:0] vb2_n;
  logic [7:0]         op_q  [ENTRIES];
  logic [DW-1:0]      v1_q  [ENTRIES];
  logic [DW-1:0]      v2_q  [ENTRIES];
  logic [DW-1:0]      v1_n  [ENTRIES];
  logic [DW-1:0]      v2_n  [ENTRIES];
  logic [2:0]         t1_q  [ENTRIES];
  logic [2:0]         t2_q  [ENTRIES];
  logic [2:0]         age_q [ENTRIES];

  logic [IW-1:0]      alloc_idx;
  logic [IW-1:0]      sel_idx;
  logic               any_ready;
  logic               do_issue;
  logic               do_disp;
  logic [7:0]         sel_op;
  logic [DW-1:0]      sel_a;
  logic [DW-1:0]      sel_b;
  logic [2:0]         sel_age;
  logic               iss_vb1;
  logic               iss_vb2;
  logic [DW-1:0]      iss_v1;
  logic [DW-1:0]      iss_v2;

  // Returns {vbit, value}; the ADD bus takes priority if both buses carry the tag.
  function automatic logic [DW:0] snoop(
    input logic          vbit,
    input logic [DW-1:0] val,
    input logic [2:0]    tag,
    input logic [2:0]    a_tag,
    input logic [DW-1:0] a_data,
    input logic [2:0]    m_tag,
    input logic [DW-1:0] m_data
  );
    if (vbit) return {1'b1, val};
    if (a_tag != 3'd0 && tag == a_tag) return {1'b1, a_data};
    if (m_tag != 3'd0 && tag == m_tag) return {1'b1, m_data};
    return {1'b0, val};
  endfunction

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      {vb1_n[i], v1_n[i]} = snoop(vb1[i], v1_q[i], t1_q[i],
                                  cdb_add_tag, cdb_add_data, cdb_mul_tag, cdb_mul_data);
      {vb2_n[i], v2_n[i]} = snoop(vb2[i], v2_q[i], t2_q[i],
                                  cdb_add_tag, cdb_add_data, cdb_mul_tag, cdb_mul_data);
    end
    {iss_vb1, iss_v1} = snoop(issue_op1_vbit, issue_op1, issue_op1_tag,
                              cdb_add_tag, cdb_add_data, cdb_mul_tag, cdb_mul_data);
    {iss_vb2, iss_v2} = snoop(issue_op2_vbit, issue_op2, issue_op2_tag,
                              cdb_add_tag, cdb_add_data, cdb_mul_tag, cdb_mul_data);
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_idx = IW'(i);
    end
    rs_full   = &busy;
    alloc_tag = rs_full ? 3'd0 : TAG_BASE + 3'(alloc_idx);
  end

  // Oldest ready entry: ages of live entries are distinct, largest wins.
  always_comb begin
    ready     = busy & vb1 & vb2;
    any_ready = 1'b0;
    sel_idx   = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready[i] && (!any_ready || age_q[i] > sel_age)) begin
        any_ready = 1'b1;
        sel_idx   = IW'(i);
        sel_op    = op_q[i];
        sel_a     = v1_q[i];
        sel_b     = v2_q[i];
        sel_age   = age_q[i];
      end
    end
    do_disp  = exu_ready & any_ready;
    do_issue = issue_valid & ~rs_full;
  end

  // Control state. Ages older than a freed entry close the gap so they stay
  // within 0..ENTRIES-1 while keeping their relative order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      vb1        <= '0;
      vb2        <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
      disp_valid <= 1'b0;
      disp_op    <= '0;
      disp_a     <= '0;
      disp_b     <= '0;
      disp_tag   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (do_issue && i == int'(alloc_idx)) begin
          busy[i]  <= 1'b1;
          vb1[i]   <= iss_vb1;
          vb2[i]   <= iss_vb2;
          age_q[i] <= '0;
        end else if (do_disp && i == int'(sel_idx)) begin
          busy[i]  <= 1'b0;
          vb1[i]   <= 1'b0;
          vb2[i]   <= 1'b0;
          age_q[i] <= '0;
        end else if (busy[i]) begin
          vb1[i]   <= vb1_n[i];
          vb2[i]   <= vb2_n[i];
          age_q[i] <= age_q[i] + 3'(do_issue) - 3'(do_disp && (age_q[i] > sel_age));
        end
      end
      disp_valid <= do_disp;
      if (do_disp) begin
        disp_op  <= sel_op;
        disp_a   <= sel_a;
        disp_b   <= sel_b;
        disp_tag <= TAG_BASE + 3'(sel_idx);
      end
    end
  end

  // Entry payload; qualified by busy/vbit so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (do_issue && i == int'(alloc_idx)) begin
        op_q[i] <= issue_op;
        v1_q[i] <= iss_v1;
        v2_q[i] <= iss_v2;
        t1_q[i] <= issue_op1_tag;
        t2_q[i] <= issue_op2_tag;
      end else if (busy[i]) begin
        v1_q[i] <= v1_n[i];
        v2_q[i] <= v2_n[i];
      end
    end
  end

endmodule
